// File: rtl/seq_hit_window_counter.sv
// seq_hit_window_counter
// Counts match pulses from the sequence detector over windows of WINDOW
// valid bit slots and hands each window's count to the status logic via a
// one-deep valid/ready output register. Saturating count, saturation flag
// and a one-cycle drop pulse when a completed result cannot be stored.
module seq_hit_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             drop
);

  localparam int POS_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Saturating increment: returns {clamp, sum}; clamp is set when a hit
  // arrives while the count is already at its maximum.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
    logic [CNT_W:0] r;
    r = {1'b0, a};
    if (b && (a == CNT_MAX)) begin
      r = {1'b1, CNT_MAX};
    end else if (b) begin
      r = {1'b0, a + CNT_W'(1'b1)};
    end else begin
      r = {1'b0, a};
    end
    return r;
  endfunction

  logic [POS_W-1:0] pos_r;
  logic [CNT_W-1:0] acc_r;
  logic             acc_sat_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic             load_s;
  logic             drop_nxt_s;
  logic             close_s;
  logic [CNT_W:0]   add_s;
  logic [CNT_W-1:0] cnt_data_r;
  logic             cnt_sat_r;
  logic             cnt_valid_r;
  logic             drop_r;

  // Window-close detect and the saturating sum of the current slot.
  always_comb begin
    add_s   = sat_add(acc_r, hit);
    close_s = en && (pos_r == POS_LAST);
  end

  // Slot position and accumulator; everything holds on en=0 slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_r     <= {POS_W{1'b0}};
      acc_r     <= {CNT_W{1'b0}};
      acc_sat_r <= 1'b0;
    end else if (close_s) begin
      pos_r     <= {POS_W{1'b0}};
      acc_r     <= {CNT_W{1'b0}};
      acc_sat_r <= 1'b0;
    end else if (en) begin
      pos_r     <= pos_r + POS_W'(1'b1);
      acc_r     <= add_s[CNT_W-1:0];
      acc_sat_r <= acc_sat_r | add_s[CNT_W];
    end else begin
      pos_r     <= pos_r;
      acc_r     <= acc_r;
      acc_sat_r <= acc_sat_r;
    end
  end

  // Output FSM next state: load on close when the slot is free or being
  // drained this cycle, otherwise discard the new result and flag a drop.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    drop_nxt_s  = 1'b0;
    case (state_r)
      EMPTY: begin
        if (close_s) begin
          load_s      = 1'b1;
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (cnt_ready && close_s) begin
          load_s      = 1'b1;
          state_nxt_s = FULL;
        end else if (cnt_ready) begin
          state_nxt_s = EMPTY;
        end else if (close_s) begin
          drop_nxt_s  = 1'b1;
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // Output FSM state and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= EMPTY;
      cnt_data_r  <= {CNT_W{1'b0}};
      cnt_sat_r   <= 1'b0;
      cnt_valid_r <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_valid_r <= (state_nxt_s == FULL);
      drop_r      <= drop_nxt_s;
      if (load_s) begin
        cnt_data_r <= add_s[CNT_W-1:0];
        cnt_sat_r  <= acc_sat_r | add_s[CNT_W];
      end else begin
        cnt_data_r <= cnt_data_r;
        cnt_sat_r  <= cnt_sat_r;
      end
    end
  end

  assign cnt_data  = cnt_data_r;
  assign cnt_sat   = cnt_sat_r;
  assign cnt_valid = cnt_valid_r;
  assign drop      = drop_r;

endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Bench for seq_hit_window_counter: a WINDOW=16/CNT_W=8 instance driven by a
// table of per-clock vectors, and a CNT_W=3 instance for the saturation case.
module tb_seq_hit_window_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic       hit;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       es;
    logic       edrop;
    logic       chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst8 = 1'b0, en8 = 1'b0, hit8 = 1'b0, rdy8 = 1'b0;
  logic       rst3 = 1'b0, en3 = 1'b0, hit3 = 1'b0, rdy3 = 1'b0;
  logic [7:0] data8;
  logic [2:0] data3;
  logic       sat8, valid8, drop8, sat3, valid3, drop3;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  seq_hit_window_counter #(.WINDOW(16), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .hit(hit8),
    .cnt_data(data8), .cnt_sat(sat8), .cnt_valid(valid8),
    .cnt_ready(rdy8), .drop(drop8)
  );

  seq_hit_window_counter #(.WINDOW(16), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .hit(hit3),
    .cnt_data(data3), .cnt_sat(sat3), .cnt_valid(valid3),
    .cnt_ready(rdy3), .drop(drop3)
  );

  task automatic add(input logic r, input logic e, input logic h, input logic rd,
                     input logic ev, input logic [7:0] ed, input logic es,
                     input logic edp, input logic chk);
    vec_t v;
    v.rst = r; v.en = e; v.hit = h; v.rdy = rd;
    v.ev = ev; v.ed = ed; v.es = es; v.edrop = edp; v.chk = chk;
    tbl.push_back(v);
  endtask

  // Drive one vector to the selected instance, clock it, check #1 later.
  task automatic run_vec(input vec_t v, input logic sel3);
    logic       av, as, ad_rop;
    logic [7:0] ad;
    if (sel3) begin
      rst3 = v.rst; en3 = v.en; hit3 = v.hit; rdy3 = v.rdy;
      rst8 = 1'b1; en8 = 1'b0; hit8 = 1'b0; rdy8 = 1'b0;
    end else begin
      rst8 = v.rst; en8 = v.en; hit8 = v.hit; rdy8 = v.rdy;
      rst3 = 1'b0; en3 = 1'b0; hit3 = 1'b0; rdy3 = 1'b0;
    end
    @(posedge clk);
    #1;
    av     = sel3 ? valid3 : valid8;
    as     = sel3 ? sat3 : sat8;
    ad_rop = sel3 ? drop3 : drop8;
    ad     = sel3 ? {5'd0, data3} : data8;
    if (av !== v.ev) begin
      nerr++;
      $display("FAIL vec %0d cnt_valid: got %0b want %0b", nvec, av, v.ev);
    end
    if (ad_rop !== v.edrop) begin
      nerr++;
      $display("FAIL vec %0d drop: got %0b want %0b", nvec, ad_rop, v.edrop);
    end
    if (v.ev || v.chk) begin
      if (ad !== v.ed) begin
        nerr++;
        $display("FAIL vec %0d cnt_data: got %0d want %0d", nvec, ad, v.ed);
      end
      if (as !== v.es) begin
        nerr++;
        $display("FAIL vec %0d cnt_sat: got %0b want %0b", nvec, as, v.es);
      end
    end
    nvec++;
  endtask

  initial begin
    vec_t v;
    // Reset for 3 clocks with en=1, hit=1: all outputs zero.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    // Window: hits at pos 0, 7, 15 -> 3, reported only after slot 15.
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i == 0 || i == 7 || i == 15), 1'b1, (i == 15), 8'd3, 1'b0, 1'b0, 1'b0);
    // Next window: one hit at pos 3 -> 1; previous report drained at slot 0.
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i == 3), 1'b1, (i == 15), 8'd1, 1'b0, 1'b0, 1'b0);
    // Gapped enable: hit always on en=0 cycles, 5 hits on en=1 cycles.
    for (int k = 0; k < 32; k++) begin
      if (k % 2 == 0)
        add(1'b1, 1'b1, ((k / 2) inside {0, 2, 4, 8, 15}), 1'b1, (k == 30), 8'd5, 1'b0, 1'b0, 1'b0);
      else
        add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    end
    // Backpressure: window A (2) held, window B (4) dropped with 1-clk pulse.
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i < 2), 1'b0, (i == 15), 8'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i < 4), 1'b0, 1'b1, 8'd2, 1'b0, (i == 15), 1'b0);
    // Window C (6): ready rises on its closing edge -> replaced, no bubble.
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i < 6), (i == 15), 1'b1, (i == 15) ? 8'd6 : 8'd2, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd6, 1'b0, 1'b0, 1'b0);
    // Reset mid-op: pending report of 1, then 3 hits in pos 0-5, then reset.
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i == 0), 1'b0, (i == 15), 8'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      add(1'b1, 1'b1, (i % 2 == 0), 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    // Clean window after reset: 2 hits, full 16 slots, no carry-over.
    for (int i = 0; i < 16; i++)
      add(1'b1, 1'b1, (i == 5 || i == 10), 1'b1, (i == 15), 8'd2, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    // Saturation on CNT_W=3: reset, 16 hits -> 7 with sat; then 1 hit -> 1.
    v.rst = 1'b0; v.en = 1'b0; v.hit = 1'b0; v.rdy = 1'b1;
    v.ev = 1'b0; v.ed = 8'd0; v.es = 1'b0; v.edrop = 1'b0; v.chk = 1'b1;
    run_vec(v, 1'b1);
    v.chk = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v.rst = 1'b1; v.en = 1'b1; v.hit = 1'b1;
      v.ev = (i == 15); v.ed = 8'd7; v.es = 1'b1;
      run_vec(v, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      v.rst = 1'b1; v.en = 1'b1; v.hit = (i == 8);
      v.ev = (i == 15); v.ed = 8'd1; v.es = 1'b0;
      run_vec(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
